al_n2w: RTL
===========

Name: al_n2w

Overview:
- Narrow-to-wide packer; the counterpart stage of the wide-to-narrow aligner.
- Collects DAT_IN_W-bit beats LSB-lane-first into one DAT_OUT_W-bit word.
- Emits the word together with a last-valid-lane select in the same 0-based encoding the wide-to-narrow aligner consumes, so the two blocks chain back to back.
- Registered output with a zero-bubble valid/ready handshake on both sides.

Parameters:
- DAT_IN_W, 8, narrow (upstream) beat width in bits; power of 2.
- DAT_OUT_W, 32, wide (downstream) word width in bits; DAT_OUT_W % DAT_IN_W = 0.
- RATIO (localparam), DAT_OUT_W/DAT_IN_W, lanes per word; power of 2, at least 2.
- SEL_W (localparam), $clog2(RATIO), lane index width.

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active high
- us_vld  in  1  upstream beat valid
- us_last  in  1  beat closes the current word early (packet end)
- us_dat  in  DAT_IN_W  upstream beat data
- us_rdy  out  1  packer accepts beat this cycle
- ds_vld  out  1  wide word valid
- ds_rdy  in  1  downstream accepts word
- ds_dat  out  DAT_OUT_W  packed word, lane i = bits [i*DAT_IN_W +: DAT_IN_W]
- ds_last_vld_sel  out  SEL_W  index of last valid lane in ds_dat, 0-based

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous, active high.
- Reset values: ds_vld=0, ds_dat=0, ds_last_vld_sel=0, lane counter cnt=0, assembly register=0.
- Beat accept: acc = us_vld & us_rdy.
- Completing beat: a beat completes the word when cnt==RATIO-1 or us_last=1.
- us_rdy = ~cpl | ~ds_vld | ds_rdy, where cpl = (cnt==RATIO-1) | us_last.
  - Non-completing beats are always accepted.
  - A completing beat waits only while the output slot is held.
  - us_rdy is combinational from us_last, cnt, ds_vld and ds_rdy; there is no path from us_vld to us_rdy.
- Accepted non-completing beat: writes us_dat into assembly lane cnt; cnt <= cnt+1.
- Accepted completing beat: on the next edge:
  - ds_dat <= assembly register with lane cnt replaced by us_dat;
  - ds_last_vld_sel <= cnt; ds_vld <= 1; cnt <= 0.
- Latency: ds_vld rises on the cycle after the completing beat is accepted.
- Output hold: while ds_vld & ~ds_rdy, ds_dat and ds_last_vld_sel stay stable.
- Output drain: ds_vld & ds_rdy with no completing beat accepted in the same cycle gives ds_vld <= 0.
- Simultaneous drain + completion: new word loads and ds_vld stays 1, giving one word per RATIO beats with no bubble.
- us_last at cnt==RATIO-1 behaves identically to a full word (ds_last_vld_sel = RATIO-1).
- us_last at cnt==0 gives a single-lane word, ds_last_vld_sel=0.
- us_vld low mid-word: cnt holds and lanes already filled are kept indefinitely.
- Assembly lanes above cnt: not cleared between words unless the optional feature is enabled.
- Reset mid-word: the partial word is discarded, cnt=0, ds_vld=0 asynchronously. The first beat after reset release goes to lane 0.
- No overflow is possible: a completing beat is never accepted while the output slot is held.

Optional Feature:
- Macro: AL_N2W_ZERO_PAD_EN.
- Defined: on every completing beat, lanes above the last valid lane are forced to 0 in ds_dat, and the assembly register clears to 0 on word load.
- Undefined: lanes above ds_last_vld_sel carry stale content from earlier words. Downstream must use ds_last_vld_sel; no clearing logic is built.

Test Plan:
- Full-rate pack: IN=8, OUT=32, ds_rdy=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th beat, ds_vld=1, ds_dat=0x44332211, ds_last_vld_sel=3; us_rdy never drops.
- Back-to-back throughput: 8 beats 0x01..0x08 continuous, ds_rdy=1 -> ds_dat=0x04030201 then 0x08070605 on consecutive cycles, ds_vld held high across the boundary.
- Early last: 0xAA, then 0xBB with us_last=1 -> ds_last_vld_sel=1 and ds_dat[15:0]=0xBBAA. With AL_N2W_ZERO_PAD_EN, ds_dat=0x0000BBAA; without it, the upper lanes equal the previous word's lanes 2-3.
- Backpressure: hold ds_rdy=0 with a word pending, feed 4 beats ->
  - the first 3 beats are accepted;
  - us_rdy=0 on the 4th until ds_rdy=1, and the 4th beat is accepted in that same cycle;
  - the pending word stays stable throughout, and the new word follows on the next cycle.
- Reset mid-word: accept 0x55,0x66, assert rst -> ds_vld=0 immediately. After release, 0x01..0x04 gives ds_dat=0x04030201 with no 0x55/0x66 remnants.
- Single-lane last with stall: us_last on the first beat 0x7E while ds_vld=1 and ds_rdy=0 -> us_rdy=0. Once ds_rdy=1, the beat is accepted and the next word is ds_last_vld_sel=0 with ds_dat[7:0]=0x7E.

Source files
------------

// File: rtl/al_n2w.sv
// Narrow-to-wide packer: gathers DAT_IN_W beats LSB lane first into one word.
// Optional macro AL_N2W_ZERO_PAD_EN zeroes lanes above the last valid lane.
module al_n2w #(
  parameter int DAT_IN_W  = 8,
  parameter int DAT_OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 us_vld,
  input  logic                 us_last,
  input  logic [DAT_IN_W-1:0]  us_dat,
  output logic                 us_rdy,
  output logic                 ds_vld,
  input  logic                 ds_rdy,
  output logic [DAT_OUT_W-1:0] ds_dat,
  output logic [$clog2(DAT_OUT_W/DAT_IN_W)-1:0] ds_last_vld_sel
);

  localparam int RATIO = DAT_OUT_W / DAT_IN_W;
  localparam int SEL_W = $clog2(RATIO);
  localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(RATIO - 1);

  logic [SEL_W-1:0]     cnt;
  logic [DAT_OUT_W-1:0] asm_q;
  logic [DAT_OUT_W-1:0] wr_word;
  logic [DAT_OUT_W-1:0] out_word;
  logic                 cpl;
  logic                 acc;

  assign cpl    = (cnt == CNT_MAX) | us_last;
  assign us_rdy = ~cpl | ~ds_vld | ds_rdy;
  assign acc    = us_vld & us_rdy;

  // Assembly image with lane cnt overwritten by the incoming beat
  always_comb begin
    wr_word  = asm_q;
    out_word = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (SEL_W'(i) == cnt) begin
        wr_word[i*DAT_IN_W +: DAT_IN_W]  = us_dat;
        out_word[i*DAT_IN_W +: DAT_IN_W] = us_dat;
      end
`ifdef AL_N2W_ZERO_PAD_EN
      else if (SEL_W'(i) > cnt) begin
        out_word[i*DAT_IN_W +: DAT_IN_W] = '0;
      end
`endif
    end
  end

  // Lane counter and assembly register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (acc) begin
      if (cpl) begin
        cnt <= '0;
`ifdef AL_N2W_ZERO_PAD_EN
        asm_q <= '0;
`else
        asm_q <= wr_word;
`endif
      end else begin
        cnt   <= cnt + SEL_W'(1);
        asm_q <= wr_word;
      end
    end
  end

  // Output slot: load on completion, drain on ds_rdy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_vld          <= 1'b0;
      ds_dat          <= '0;
      ds_last_vld_sel <= '0;
    end else if (acc && cpl) begin
      ds_vld          <= 1'b1;
      ds_dat          <= out_word;
      ds_last_vld_sel <= cnt;
    end else if (ds_rdy) begin
      ds_vld <= 1'b0;
    end
  end

endmodule
